hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline control unit. Drives E_bubble and the other stall/bubble controls of the F/D/E pipeline registers.
//  Compares decode-stage sources against the load destination held in E, so it is the control side of the E_reg interface.
//  Squashes wrong-path instructions on a branch/jump mispredict resolved in E.
//  Sequences the multi-cycle MULT/DIV unit: counts its latency and stalls HI/LO consumers until the result is ready.
// PARAMETERS
//  MUL_LAT  4   MULT latency in cycles, 1..32
//  DIV_LAT  16  DIV latency in cycles, 1..32
//  CNT_W    16  width of the stall-cycle performance counter
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous reset, active low
//  d_srcA         in   5      decode-stage source register A (`RNONE if unused)
//  d_srcB         in   5      decode-stage source register B (`RNONE if unused)
//  E_dstM         in   5      load destination of the instruction in E (`RNONE if not a load)
//  e_mispredict   in   1      branch/jump in E resolved to the wrong path
//  e_md_start     in   1      MULT/DIV in E, valid for one cycle
//  e_md_is_div    in   1      qualifies e_md_start: 1 = DIV, 0 = MULT
//  d_uses_hilo    in   1      instruction in D reads HI/LO or is itself a MULT/DIV
//  F_stall        out  1      hold the fetch PC register
//  D_stall        out  1      hold the D register
//  D_bubble       out  1      load a NOP into the D register
//  E_bubble       out  1      load a NOP into the E register (the E_bubble input of E_reg)
//  md_busy        out  1      MULT/DIV unit is in the BUSY state
//  md_done        out  1      one-cycle pulse: HI/LO are written at the next rising edge
//  stall_cnt      out  CNT_W  count of cycles with F_stall=1; saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - state=IDLE, md_cnt=0, stall_cnt=0.
//   - F_stall=D_stall=0, md_busy=md_done=0.
//   - D_bubble=E_bubble=1 so the unreset pipeline registers fill with NOPs.
//  MD FSM (two states, IDLE and BUSY; md_cnt is 5 bits):
//   - IDLE: when e_md_start=1 and e_mispredict=0, go to BUSY. Load md_cnt with DIV_LAT-1 if e_md_is_div=1, else MUL_LAT-1.
//   - BUSY: md_busy=1. If md_cnt!=0, decrement md_cnt. If md_cnt==0, md_done=1 and go to IDLE at the next edge.
//   - A start at edge k gives LAT cycles of BUSY. md_done is high in the last of those cycles.
//   - e_md_start while BUSY is ignored; it cannot occur legally because D is stalled.
//  Hazard terms (combinational):
//   - lu = (E_dstM != `RNONE) && (E_dstM != 0) && (E_dstM == d_srcA || E_dstM == d_srcB).
//   - md = md_busy && !md_done && d_uses_hilo.
//  Output priority:
//   1. e_mispredict=1: D_bubble=1, E_bubble=1, F_stall=0, D_stall=0. lu and md are ignored. The MD FSM keeps counting.
//   2. Otherwise, lu or md: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
//   3. Otherwise all four outputs are 0.
//  Release timing:
//   - In the md_done cycle the stall releases, so the HI/LO reader enters E after HI/LO are written.
//   - A load-use stall lasts exactly one cycle, because the bubble clears E_dstM.
//  stall_cnt: +1 at every edge with F_stall=1; holds at 2^CNT_W-1.
//  Reset mid-BUSY: FSM returns to IDLE immediately and md_done is not produced.
// TESTING
//  1. Reset: hold rst_n=0 with random inputs -> D_bubble=E_bubble=1, all other outputs 0.
//     Release reset with no hazards -> all control outputs 0.
//  2. Load-use: E_dstM=8, d_srcB=8 -> F_stall=D_stall=E_bubble=1 for exactly 1 cycle; stall_cnt=1.
//     E_dstM=0 with d_srcA=0 -> no stall.
//  3. MULT then MFHI: e_md_start=1, e_md_is_div=0, d_uses_hilo=1 -> md_busy for 4 cycles.
//     F_stall high for the first 3 cycles; md_done and stall release in cycle 4.
//  4. DIV: e_md_is_div=1 -> md_done exactly 16 cycles after start.
//     With d_uses_hilo=0 throughout -> no stalls at all.
//  5. Mispredict during load-use and during BUSY -> D_bubble=E_bubble=1, F_stall=0.
//     The MD FSM still finishes on schedule.
//  6. Assert rst_n=0 mid-DIV -> md_busy falls asynchronously; no md_done.
//     Run with CNT_W=4 and 20 stalls -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble control for the F/D/E pipeline registers (load-use, mispredict, MULT/DIV sequencing)
// and a saturating counter of fetch-stall cycles.
module hazard_ctrl #(
    parameter int         MUL_LAT = 4,
    parameter int         DIV_LAT = 16,
    parameter int         CNT_W   = 16,
    parameter logic [4:0] RNONE   = 5'h1f
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       d_srcA,
    input  logic [4:0]       d_srcB,
    input  logic [4:0]       E_dstM,
    input  logic             e_mispredict,
    input  logic             e_md_start,
    input  logic             e_md_is_div,
    input  logic             d_uses_hilo,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [4:0] MUL_LD = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_LD = 5'(DIV_LAT - 1);

    state_t           r_state;
    logic [4:0]       r_md_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_lu, w_md, w_hazard;

    assign w_lu = (E_dstM != RNONE) && (E_dstM != 5'd0) && (E_dstM == d_srcA || E_dstM == d_srcB);
    assign md_busy = r_state == BUSY;
    assign md_done = md_busy && r_md_cnt == 5'd0;
    // The md_done cycle already releases the stall: HI/LO are written at the coming edge.
    assign w_md = md_busy && !md_done && d_uses_hilo;
    assign w_hazard = rst_n && !e_mispredict && (w_lu || w_md);
    assign F_stall = w_hazard;
    assign D_stall = w_hazard;
    // Bubbles are forced during reset so the unreset pipeline registers fill with NOPs.
    assign D_bubble = !rst_n || e_mispredict;
    assign E_bubble = D_bubble || w_hazard;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_md_cnt    <= 5'd0;
            r_stall_cnt <= '0;
        end else begin
            if (F_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (r_state == IDLE) begin
                if (e_md_start && !e_mispredict) begin
                    r_state  <= BUSY;
                    r_md_cnt <= e_md_is_div ? DIV_LD : MUL_LD;
                end
            end else if (r_md_cnt == 5'd0)
                r_state <= IDLE;
            else
                r_md_cnt <= r_md_cnt - 1'b1;
        end
    end
endmodule
